// File: rtl/grant_mux_pkg.sv
// Shared types and helpers for grant_mux.
package grant_mux_pkg;

  localparam int unsigned SRC_W = 2;

  typedef logic [SRC_W-1:0] src_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam src_t SRC0 = SRC_W'(0);
  localparam src_t SRC1 = SRC_W'(1);
  localparam src_t SRC2 = SRC_W'(2);

  // Decoded grant: index of the granted client plus an exactly-one-hot flag.
  typedef struct packed {
    logic single;
    src_t idx;
  } grant_dec_t;

  // Encode a 3-bit grant vector; single is clear for 000 and any multi-hot value.
  function automatic grant_dec_t onehot3_to_idx(input logic [2:0] g);
    grant_dec_t r;
    r.single = 1'b0;
    r.idx    = SRC0;
    case (g)
      3'b001: begin r.single = 1'b1; r.idx = SRC0; end
      3'b010: begin r.single = 1'b1; r.idx = SRC1; end
      3'b100: begin r.single = 1'b1; r.idx = SRC2; end
      default: begin r.single = 1'b0; r.idx = SRC0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/grant_mux_grant_decode.sv
// Combinational one-hot check and index encode of the arbiter grant vector.
module grant_decode
  import grant_mux_pkg::*;
(
  input  logic [2:0] grant,
  output logic       single_c,
  output logic       multi_c,
  output src_t       idx_c
);

  grant_dec_t dec_c;

  // Decode grant into index and single/multi flags.
  always_comb begin
    dec_c    = onehot3_to_idx(grant);
    single_c = dec_c.single;
    idx_c    = dec_c.idx;
    multi_c  = (|grant) & ~dec_c.single;
  end

endmodule

// File: rtl/grant_mux.sv
// Grant-driven 3:1 data mux with a one-entry valid/ready output stage.
// Optional per-client beat counters are built when GRANT_MUX_STATS_EN is defined.
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              grant0,
  input  logic              grant1,
  input  logic              grant2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              ack0,
  output logic              ack1,
  output logic              ack2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SRC_W-1:0]  out_src,
  output logic              out_first,
  output logic              err_multi,
`ifdef GRANT_MUX_STATS_EN
  output logic [CNT_W-1:0]  beats0,
  output logic [CNT_W-1:0]  beats1,
  output logic [CNT_W-1:0]  beats2,
`endif
  input  logic              err_clr
);

  state_t            state;
  state_t            state_nxt;
  logic              dec_single_c;
  logic              dec_multi_c;
  src_t              dec_idx_c;
  logic              load_c;
  logic              accept_c;
  logic [DATA_W-1:0] data_sel_c;
  logic              prev_vld_c;
  src_t              prev_src_c;
  logic              first_c;
  logic              err_nxt_c;
  src_t              last_src;
  logic              last_src_vld;

  grant_decode u_grant_decode (
    .grant    ({grant2, grant1, grant0}),
    .single_c (dec_single_c),
    .multi_c  (dec_multi_c),
    .idx_c    (dec_idx_c)
  );

  assign out_valid = (state == ST_FULL);
  assign accept_c  = out_valid & out_ready;

  assign ack0 = grant0 & load_c;
  assign ack1 = grant1 & load_c;
  assign ack2 = grant2 & load_c;

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and load decision; a load is possible whenever the slot is or becomes free.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_c = dec_single_c;
        if (load_c) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        load_c = dec_single_c & out_ready;
        if (out_ready && !load_c) state_nxt = ST_EMPTY;
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Data select, first-beat detection and sticky error next value.
  always_comb begin
    data_sel_c = '0;
    case (dec_idx_c)
      SRC0:    data_sel_c = data0;
      SRC1:    data_sel_c = data1;
      SRC2:    data_sel_c = data2;
      default: data_sel_c = '0;
    endcase
    // A beat accepted this cycle is the previous beat for a same-cycle reload.
    prev_vld_c = accept_c | last_src_vld;
    prev_src_c = accept_c ? out_src : last_src;
    first_c    = ~prev_vld_c | (dec_idx_c != prev_src_c);
    err_nxt_c  = err_multi;
    if (err_clr)     err_nxt_c = 1'b0;
    if (dec_multi_c) err_nxt_c = 1'b1;
  end

  // Output stage, last-accepted-source tracking and error flag.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_data     <= '0;
      out_src      <= SRC0;
      out_first    <= 1'b0;
      last_src     <= SRC0;
      last_src_vld <= 1'b0;
      err_multi    <= 1'b0;
    end else begin
      if (load_c) begin
        out_data  <= data_sel_c;
        out_src   <= dec_idx_c;
        out_first <= first_c;
      end
      if (accept_c) begin
        last_src     <= out_src;
        last_src_vld <= 1'b1;
      end
      err_multi <= err_nxt_c;
    end
  end

`ifdef GRANT_MUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating per-client accepted-beat counters, cleared with the error flag.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      beats0 <= '0;
      beats1 <= '0;
      beats2 <= '0;
    end else if (err_clr) begin
      beats0 <= '0;
      beats1 <= '0;
      beats2 <= '0;
    end else if (accept_c) begin
      case (out_src)
        SRC0:    if (beats0 != CNT_MAX) beats0 <= beats0 + CNT_W'(1);
        SRC1:    if (beats1 != CNT_MAX) beats1 <= beats1 + CNT_W'(1);
        SRC2:    if (beats2 != CNT_MAX) beats2 <= beats2 + CNT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_grant_mux.sv
// Randomized self-checking bench for grant_mux against a transaction-level model.
module tb_grant_mux;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              res_n;
  logic              grant0, grant1, grant2;
  logic [DATA_W-1:0] data0, data1, data2;
  logic              ack0, ack1, ack2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              out_first;
  logic              err_multi;
  logic              err_clr;
`ifdef GRANT_MUX_STATS_EN
  logic [CNT_W-1:0]  beats0, beats1, beats2;
`endif

  grant_mux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant2    (grant2),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .ack0      (ack0),
    .ack1      (ack1),
    .ack2      (ack2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_first (out_first),
    .err_multi (err_multi),
`ifdef GRANT_MUX_STATS_EN
    .beats0    (beats0),
    .beats1    (beats1),
    .beats2    (beats2),
`endif
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: the held beat and history at transaction level.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_src;
  logic              m_first;
  int                m_last;   // -1: no beat accepted since reset
  logic              m_err;
  int                m_cnt[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_first = 1'b0;
    m_last  = -1;
    m_err   = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, "_data"},  64'(out_data),  64'(m_data));
    check({tag, "_src"},   64'(out_src),   64'(m_src));
    check({tag, "_first"}, 64'(out_first), 64'(m_first));
    check({tag, "_err"},   64'(err_multi), 64'(m_err));
`ifdef GRANT_MUX_STATS_EN
    check({tag, "_beats0"}, 64'(beats0), 64'(m_cnt[0]));
    check({tag, "_beats1"}, 64'(beats1), 64'(m_cnt[1]));
    check({tag, "_beats2"}, 64'(beats2), 64'(m_cnt[2]));
`endif
  endtask

  // One clock: drive inputs, check acks, advance the model, check registered outputs.
  // Entered and left one time unit after a rising edge.
  task automatic cycle(input string tag, input logic [2:0] g, input logic rdy, input logic clr);
    int                ones;
    int                idx;
    logic              load;
    logic              acc;
    logic [DATA_W-1:0] d[3];
    grant0 = g[0]; grant1 = g[1]; grant2 = g[2];
    out_ready = rdy;
    err_clr   = clr;
    d[0] = data0; d[1] = data1; d[2] = data2;
    ones = $countones(g);
    idx  = g[0] ? 0 : (g[1] ? 1 : 2);
    load = (ones == 1) && (!m_valid || rdy);
    #1;
    check({tag, "_ack0"}, 64'(ack0), 64'(load && g[0]));
    check({tag, "_ack1"}, 64'(ack1), 64'(load && g[1]));
    check({tag, "_ack2"}, 64'(ack2), 64'(load && g[2]));
    @(posedge clk);
    acc = m_valid && rdy;
    if (clr) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (acc && m_cnt[m_src] < (1 << CNT_W) - 1) begin
      m_cnt[m_src] = m_cnt[m_src] + 1;
    end
    if (acc) m_last = m_src;
    if (load) begin
      m_first = (m_last < 0) || (m_last != idx);
      m_data  = d[idx];
      m_src   = idx;
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (ones >= 2) m_err = 1'b1;
    else if (clr)  m_err = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    res_n  = 1'b0;
    grant0 = 1'b0; grant1 = 1'b0; grant2 = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    check("rst_ack0", 64'(ack0), 64'd0);
    @(posedge clk);
    #1;
    res_n = 1'b1;
  endtask

  logic [2:0] g_rand;
  int         pick;
  logic [2:0] stream_g[5];
  logic       stream_first[5];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    res_n  = 1'b0;
    grant0 = 1'b0; grant1 = 1'b0; grant2 = 1'b0;
    data0 = '0; data1 = '0; data2 = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("rst_init");
    res_n = 1'b1;

    // Reset while a beat is held under backpressure.
    data0 = 32'hA5;
    cycle("bp_load", 3'b001, 1'b0, 1'b0);
    check("bp_held_data", 64'(out_data), 64'hA5);
    apply_reset();
    check("rst_mid_data", 64'(out_data), 64'd0);
    cycle("post_rst0", 3'b000, 1'b0, 1'b0);
    cycle("post_rst1", 3'b000, 1'b1, 1'b0);

    // Single beat from client 1.
    data1 = 32'h1234;
    cycle("single", 3'b010, 1'b1, 1'b0);
    check("single_data_k", 64'(out_data), 64'h1234);
    check("single_src_k",  64'(out_src),  64'd1);
    check("single_first_k", 64'(out_first), 64'd1);

    // Streaming run 0,0,2,2,1 with first-flag pattern 1,0,1,0,1.
    stream_g     = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b010};
    stream_first = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      data0 = $urandom; data1 = $urandom; data2 = $urandom;
      cycle("stream", stream_g[i], 1'b1, 1'b0);
      check("stream_first_k", 64'(out_first), 64'(stream_first[i]));
      check("stream_valid_k", 64'(out_valid), 64'd1);
    end
    cycle("drain", 3'b000, 1'b1, 1'b0);
    check("drain_valid_k", 64'(out_valid), 64'd0);

    // Backpressure: hold grant0 while the sink stalls, then release.
    data0 = 32'hCAFE_0001;
    cycle("bp0", 3'b001, 1'b0, 1'b0);
    data0 = 32'hCAFE_0002;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall", 3'b001, 1'b0, 1'b0);
      check("bp_stable_k", 64'(out_data), 64'hCAFE_0001);
    end
    cycle("bp_release", 3'b001, 1'b1, 1'b0);
    check("bp_reload_k", 64'(out_data), 64'hCAFE_0002);
    cycle("bp_drain", 3'b000, 1'b1, 1'b0);

    // Multi-hot grant, clear, and clear colliding with a new multi-hot.
    cycle("multi", 3'b101, 1'b1, 1'b0);
    check("multi_err_k", 64'(err_multi), 64'd1);
    cycle("multi_hold", 3'b000, 1'b0, 1'b0);
    cycle("multi_clr", 3'b000, 1'b0, 1'b1);
    check("multi_clr_k", 64'(err_multi), 64'd0);
    cycle("multi_setwins", 3'b011, 1'b0, 1'b1);
    check("multi_setwins_k", 64'(err_multi), 64'd1);
    cycle("multi_clr2", 3'b000, 1'b1, 1'b1);

`ifdef GRANT_MUX_STATS_EN
    // Four beats from client 2, one from client 0.
    for (int i = 0; i < 4; i++) cycle("st2", 3'b100, 1'b1, 1'b0);
    cycle("st0", 3'b001, 1'b1, 1'b0);
    cycle("st_drain", 3'b000, 1'b1, 1'b0);
    check("stats_b2_k", 64'(beats2), 64'd4);
    check("stats_b0_k", 64'(beats0), 64'd1);
    check("stats_b1_k", 64'(beats1), 64'd0);
`endif

    // Randomized traffic: mostly single grants, some idle and multi-hot vectors.
    for (int n = 0; n < 600; n++) begin
      data0 = $urandom; data1 = $urandom; data2 = $urandom;
      pick = int'($urandom_range(0, 9));
      if (pick < 6)       g_rand = 3'(1 << $urandom_range(0, 2));
      else if (pick < 8)  g_rand = 3'b000;
      else                g_rand = 3'($urandom_range(0, 7));
      cycle("rand", g_rand, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      if (n == 300) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
